// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART serializer (TX) and deserializer (RX).
//   Holds the frame geometry, the default bit period and the FSM state type.
//
//   Contents:
//     DATA_BITS         data bits per frame (8N1)
//     STOP_BITS         stop bits per frame
//     CLKS_PER_BIT_DEF  default clock cycles per bit (12 MHz / 115200)
//     uart_state_e      IDLE, FETCH, START, DATA, STOP
//     cnt_width()       counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int STOP_BITS        = 1;
  localparam int CLKS_PER_BIT_DEF = 104;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Width able to hold 0..n-1; clamped to 1 so degenerate sizes still elaborate.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_8n1_if.sv
// -----------------------------------------------------------------------------
// uart_tx_8n1_if
//   FIFO read-port bundle between the TX FIFO and the 8N1 serializer.
//
//   Signals (named from the serializer's point of view):
//     i_fifo_empty    FIFO empty flag
//     i_fifo_rd_data  FIFO read data, valid RD_LATENCY cycles after a pop
//     o_fifo_rd_en    one-cycle pop strobe
//
//   Modports:
//     master  serializer side (issues pops, consumes data)
//     slave   FIFO side (answers pops)
// -----------------------------------------------------------------------------
interface uart_tx_8n1_if;
  import uart_pkg::*;

  logic                 i_fifo_empty;
  logic [DATA_BITS-1:0] i_fifo_rd_data;
  logic                 o_fifo_rd_en;

  modport master (
    input  i_fifo_empty,
    input  i_fifo_rd_data,
    output o_fifo_rd_en
  );

  modport slave (
    output i_fifo_empty,
    output i_fifo_rd_data,
    input  o_fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0
//   on its own last cycle, so consecutive bits are exactly CLKS_PER_BIT long
//   with no accumulated drift. tick marks the last cycle of the current bit.
//
//   Ports:
//     i_clk   clock
//     reset   synchronous, active-high reset (counter to 0)
//     clr     synchronous clear, holds the counter at 0 between frames
//     en      count enable
//     tick    high during the last cycle of a bit period (combinational)
// -----------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic i_clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// -----------------------------------------------------------------------------
// uart_tx_8n1
//   8N1 UART serializer on the drain side of the TX FIFO. Pops one byte at a
//   time and sends start bit, 8 data bits LSB-first and one stop bit. A new
//   byte can be popped in the last stop-bit cycle so that frames run
//   back-to-back with an RD_LATENCY+1 cycle high gap.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//     RD_LATENCY    cycles from pop strobe to valid FIFO read data
//
//   Ports:
//     i_clk    single clock, shared with the FIFO read side
//     reset    synchronous, active-high reset
//     i_tx_en  permission to start new frames; a running frame always completes
//     fifo     FIFO read port (master modport)
//     o_tx     serial line, idle high, registered
//     o_busy   high from the pop cycle through the last stop-bit cycle
// -----------------------------------------------------------------------------
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int RD_LATENCY   = 1
) (
  input  logic          i_clk,
  input  logic          reset,
  input  logic          i_tx_en,
  uart_tx_8n1_if.master fifo,
  output logic          o_tx,
  output logic          o_busy
);

  localparam int            FW         = cnt_width(RD_LATENCY + 1);
  localparam int            BW         = cnt_width(DATA_BITS);
  localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LATENCY);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [FW-1:0]        fetch_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;

  logic                 tx_q;
  logic                 busy_q;
  logic                 rd_en_q;
  logic                 tx_d;
  logic                 busy_d;
  logic                 rd_en_d;

  logic                 can_pop;
  logic                 fetch_done;
  logic                 baud_en;
  logic                 baud_tick;

  // A pop is only ever requested from IDLE or the last stop cycle, so at most
  // one byte is in flight between the pop and the latch at the end of FETCH.
  assign can_pop    = i_tx_en && !fifo.i_fifo_empty;
  assign fetch_done = (state_q == FETCH) && (fetch_cnt_q == FETCH_LAST);
  assign baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .i_clk (i_clk),
    .reset (reset),
    .clr   (!baud_en),
    .en    (baud_en),
    .tick  (baud_tick)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_pop) state_d = FETCH;
      end
      FETCH: begin
        if (fetch_done) state_d = START;
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick && (bit_cnt_q == BIT_LAST)) state_d = STOP;
      end
      STOP: begin
        if (baud_tick && (bit_cnt_q == STOP_LAST)) begin
          state_d = can_pop ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Entering FETCH is exactly the pop cycle, from IDLE or from the last stop.
    rd_en_d = (state_d == FETCH) && (state_q != FETCH);
    busy_d  = (state_d != IDLE);
    tx_d    = 1'b1;
    unique case (state_d)
      START: tx_d = 1'b0;
      DATA: begin
        // Bit 0 is presented on the START->DATA edge; later bits come from the
        // next position of the shift register, which shifts on the same tick.
        if (state_q == START)  tx_d = shift_q[0];
        else if (baud_tick)    tx_d = shift_q[1];
        else                   tx_d = tx_q;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
    end else begin
      fetch_cnt_q <= ((state_q == FETCH) && !fetch_done) ? fetch_cnt_q + 1'b1 : '0;

      if (fetch_done) begin
        shift_q <= fifo.i_fifo_rd_data;
      end else if ((state_q == DATA) && baud_tick) begin
        shift_q <= shift_q >> 1;
      end

      // The bit counter wraps 7->0 when DATA is left and is then reused to
      // count stop bits.
      if (baud_tick) begin
        if (state_q == DATA) begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end else if (state_q == STOP) begin
          bit_cnt_q <= (bit_cnt_q == STOP_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (reset) begin
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign o_tx              = tx_q;
  assign o_busy            = busy_q;
  assign fifo.o_fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
module tb_uart_tx_8n1;

  localparam int CPB_A = 4;
  localparam int CPB_B = 104;
  localparam int NB    = 40;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic rst_a, rst_b, tx_en_a, tx_en_b;
  logic tx_a, tx_b, busy_a, busy_b;

  uart_tx_8n1_if fif_a ();
  uart_tx_8n1_if fif_b ();

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB_A), .RD_LATENCY(1)) dut_a (
    .i_clk(i_clk), .reset(rst_a), .i_tx_en(tx_en_a), .fifo(fif_a),
    .o_tx(tx_a), .o_busy(busy_a));

  uart_tx_8n1 #(.CLKS_PER_BIT(CPB_B), .RD_LATENCY(1)) dut_b (
    .i_clk(i_clk), .reset(rst_b), .i_tx_en(tx_en_b), .fifo(fif_b),
    .o_tx(tx_b), .o_busy(busy_b));

  // FIFO models: memory and write pointer owned by the stimulus, read pointer
  // and registered read data owned by the clocked read side.
  logic [7:0] mem_a [0:63];
  logic [7:0] mem_b [0:63];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  int pop_empty_a = 0, pop_empty_b = 0;

  assign fif_a.i_fifo_empty = (wp_a == rp_a);
  assign fif_b.i_fifo_empty = (wp_b == rp_b);

  always @(posedge i_clk) begin
    if (rst_a) rp_a <= wp_a;
    else if (fif_a.o_fifo_rd_en === 1'b1) begin
      if (wp_a == rp_a) pop_empty_a <= pop_empty_a + 1;
      else begin
        fif_a.i_fifo_rd_data <= mem_a[rp_a];
        rp_a <= rp_a + 1;
      end
    end
  end

  always @(posedge i_clk) begin
    if (rst_b) rp_b <= wp_b;
    else if (fif_b.o_fifo_rd_en === 1'b1) begin
      if (wp_b == rp_b) pop_empty_b <= pop_empty_b + 1;
      else begin
        fif_b.i_fifo_rd_data <= mem_b[rp_b];
        rp_b <= rp_b + 1;
      end
    end
  end

  // Receiver models: mid-bit sampling, decoded bytes stored for the scoreboard.
  logic [7:0] rx_a_mem [0:63];
  logic [7:0] rx_b_mem [0:63];
  int rx_a_n = 0, rx_b_n = 0, ferr_a = 0, ferr_b = 0;

  function automatic logic line_of(input bit which);
    return which ? tx_b : tx_a;
  endfunction

  function automatic logic rst_of(input bit which);
    return which ? rst_b : rst_a;
  endfunction

  task automatic rx_frame(input bit which, input int cpb, output logic [7:0] data,
                          output bit ferr, output bit abort);
    int idx;
    data = '0; ferr = 1'b0; abort = 1'b0;
    for (int c = 1; c <= cpb / 2 + 9 * cpb; c++) begin
      @(negedge i_clk);
      if (rst_of(which) === 1'b1) begin abort = 1'b1; return; end
      if (c >= cpb / 2 && ((c - cpb / 2) % cpb) == 0) begin
        idx = (c - cpb / 2) / cpb;
        if (idx == 0) begin
          if (line_of(which) !== 1'b0) begin abort = 1'b1; return; end
        end else if (idx <= 8) data[idx-1] = line_of(which);
        else ferr = (line_of(which) !== 1'b1);
      end
    end
  endtask

  always begin : rx_a_proc
    logic [7:0] b; bit fe, ab;
    @(negedge i_clk);
    if (rst_a === 1'b0 && tx_a === 1'b0) begin
      rx_frame(1'b0, CPB_A, b, fe, ab);
      if (!ab && rx_a_n < 64) begin
        rx_a_mem[rx_a_n] = b; rx_a_n++;
        if (fe) ferr_a++;
      end
    end
  end

  always begin : rx_b_proc
    logic [7:0] b; bit fe, ab;
    @(negedge i_clk);
    if (rst_b === 1'b0 && tx_b === 1'b0) begin
      rx_frame(1'b1, CPB_B, b, fe, ab);
      if (!ab && rx_b_n < 64) begin
        rx_b_mem[rx_b_n] = b; rx_b_n++;
        if (fe) ferr_b++;
      end
    end
  end

  // Checking and scoreboard state, owned by the stimulus process.
  int checks = 0, errors = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int rx_a_rd = 0;
  logic tx_log [0:255];
  logic busy_log [0:255];
  int r_rden, r_low, r_busy;
  int s1, s2, wait_n;
  logic [63:0] obs_w, exp_w;
  logic [7:0] byte_v, rb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] b, input bit track);
    mem_a[wp_a] = b;
    wp_a = wp_a + 1;
    if (track) exp_a.push_back(b);
  endtask

  task automatic observe(input int n, output int rden_n, output int low_n, output int busy_n);
    rden_n = 0; low_n = 0; busy_n = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge i_clk);
      tx_log[j] = tx_a;
      busy_log[j] = busy_a;
      if (fif_a.o_fifo_rd_en === 1'b1) rden_n++;
      if (tx_a !== 1'b1) low_n++;
      if (busy_a !== 1'b0) busy_n++;
    end
  endtask

  task automatic sb_check_a(input int budget);
    int n;
    logic [7:0] e;
    n = 0;
    while ((rx_a_n < rx_a_rd + exp_a.size()) && (n < budget)) begin
      @(negedge i_clk);
      n++;
    end
    check("sb_a_count", 64'(rx_a_n - rx_a_rd), 64'(exp_a.size()));
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      if (rx_a_rd < rx_a_n) begin
        check("sb_a_byte", 64'(rx_a_mem[rx_a_rd]), 64'(e));
        rx_a_rd++;
      end
    end
  endtask

  function automatic int first_low(input int from, input int n);
    for (int j = from; j < n; j++) if (tx_log[j] === 1'b0) return j;
    return -1;
  endfunction

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; tx_en_a = 1'b0; tx_en_b = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_tx_a", 64'(tx_a), 64'(1));
    check("rst_busy_a", 64'(busy_a), 64'(0));
    check("rst_rden_a", 64'(fif_a.o_fifo_rd_en), 64'(0));
    check("rst_tx_b", 64'(tx_b), 64'(1));
    rst_a = 1'b0; rst_b = 1'b0; tx_en_a = 1'b1;
    repeat (2) @(negedge i_clk);

    // Single byte 0x55: decision, pop, fetch, then 40 cycles of frame.
    push_a(8'h55, 1'b1);
    observe(50, r_rden, r_low, r_busy);
    s1 = first_low(0, 50);
    check("t1_start_latency", 64'(s1), 64'(2));
    if (s1 < 0) s1 = 0;
    byte_v = 8'h55;
    obs_w = '0; exp_w = '0;
    for (int j = 0; j < 40; j++) begin
      obs_w[j] = (s1 + j < 50) ? tx_log[s1 + j] : 1'bx;
      if (j / 4 == 0) exp_w[j] = 1'b0;
      else if (j / 4 == 9) exp_w[j] = 1'b1;
      else exp_w[j] = byte_v[j / 4 - 1];
    end
    check("t1_wave", obs_w, exp_w);
    check("t1_rden_pulses", 64'(r_rden), 64'(1));
    check("t1_low_cycles", 64'(r_low), 64'(20));
    check("t1_busy_cycles", 64'(r_busy), 64'(42));
    check("t1_busy_end", 64'(busy_log[49]), 64'(0));
    sb_check_a(200);

    // Two bytes back-to-back with a 2-cycle high gap.
    @(negedge i_clk);
    push_a(8'hA5, 1'b1);
    push_a(8'h3C, 1'b1);
    observe(100, r_rden, r_low, r_busy);
    s1 = first_low(0, 100);
    if (s1 < 0) s1 = 0;
    s2 = first_low(s1 + 40, 100);
    check("t2_gap", 64'(s2 - (s1 + 40)), 64'(2));
    check("t2_rden_pulses", 64'(r_rden), 64'(2));
    check("t2_busy_cycles", 64'(r_busy), 64'(84));
    sb_check_a(200);

    // Empty FIFO with transmission enabled: nothing moves.
    observe(200, r_rden, r_low, r_busy);
    check("t3_no_pop", 64'(r_rden), 64'(0));
    check("t3_tx_idle", 64'(r_low), 64'(0));
    check("t3_busy_low", 64'(r_busy), 64'(0));

    // Reset during data bit 3 of 0xF0: frame abandoned, byte lost.
    push_a(8'hF0, 1'b0);
    repeat (20) @(negedge i_clk);
    check("t4_mid_tx", 64'(tx_a), 64'(0));
    check("t4_mid_busy", 64'(busy_a), 64'(1));
    rst_a = 1'b1;
    @(negedge i_clk);
    check("t4_rst_tx", 64'(tx_a), 64'(1));
    check("t4_rst_busy", 64'(busy_a), 64'(0));
    observe(4, r_rden, r_low, r_busy);
    check("t4_no_pop_in_rst", 64'(r_rden), 64'(0));
    rst_a = 1'b0;
    observe(12, r_rden, r_low, r_busy);
    check("t4_no_pop_empty", 64'(r_rden), 64'(0));
    check("t4_tx_idle", 64'(r_low), 64'(0));
    push_a(8'h11, 1'b1);
    observe(50, r_rden, r_low, r_busy);
    check("t4_pop_after", 64'(r_rden), 64'(1));
    sb_check_a(200);

    // Enable dropped during START of 0x81 with two more bytes queued.
    push_a(8'h81, 1'b1);
    push_a(8'h42, 1'b1);
    push_a(8'h24, 1'b1);
    observe(4, r_rden, r_low, r_busy);
    check("t5_first_pop", 64'(r_rden), 64'(1));
    check("t5_in_start", 64'(tx_a), 64'(0));
    tx_en_a = 1'b0;
    observe(80, r_rden, r_low, r_busy);
    check("t5_no_pop_disabled", 64'(r_rden), 64'(0));
    check("t5_idle_busy", 64'(busy_a), 64'(0));
    check("t5_idle_tx", 64'(tx_a), 64'(1));
    tx_en_a = 1'b1;
    observe(100, r_rden, r_low, r_busy);
    check("t5_resume_pops", 64'(r_rden), 64'(2));
    sb_check_a(200);

    // Full-rate bit period with random bytes.
    for (int i = 0; i < NB; i++) begin
      rb = 8'($urandom_range(0, 255));
      mem_b[wp_b] = rb;
      wp_b = wp_b + 1;
      exp_b.push_back(rb);
    end
    tx_en_b = 1'b1;
    wait_n = 0;
    while (rx_b_n < NB && wait_n < 50000) begin
      @(negedge i_clk);
      wait_n++;
    end
    check("t6_count", 64'(rx_b_n), 64'(NB));
    for (int i = 0; i < NB; i++) begin
      rb = exp_b.pop_front();
      if (i < rx_b_n) check("t6_byte", 64'(rx_b_mem[i]), 64'(rb));
    end
    repeat (60) @(negedge i_clk);
    check("t6_busy_end", 64'(busy_b), 64'(0));
    check("t6_tx_end", 64'(tx_b), 64'(1));

    check("framing_a", 64'(ferr_a), 64'(0));
    check("framing_b", 64'(ferr_b), 64'(0));
    check("pop_empty_a", 64'(pop_empty_a), 64'(0));
    check("pop_empty_b", 64'(pop_empty_b), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
